tone_noise_bank: RTL and testbench
==================================

TONE_NOISE_BANK -- requirements
Module: tone_noise_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent generator channels, legal range 1..16.
REQ-002 Parameter DIV_WIDTH, default 20: width of each channel's divisor register and counter.
REQ-003 Parameter LFSR_WIDTH, fixed at 8: width of each channel's noise shift register.
REQ-004 Port clk, input, 1 bit: sole clock; all state changes on the rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port cfg_we, input, 1 bit: configuration write strobe, one write per cycle.
REQ-007 Port cfg_addr, input, 4 bits: index of the channel being written.
REQ-008 Port cfg_div, input, DIV_WIDTH bits: divisor; channel ticks every cfg_div+1 cycles.
REQ-009 Port cfg_mode, input, 1 bit: 0 = square, 1 = noise.
REQ-010 Port cfg_en, input, 1 bit: channel enable.
REQ-011 Port out, output, CHANNELS bits: registered per-channel audio bit.
REQ-012 Port active_count, output, ceil(log2(CHANNELS+1)) bits: registered population count of out.

Function
REQ-013 Each channel SHALL hold div, mode and en registers, a DIV_WIDTH down-counter, a phase bit and an 8-bit LFSR.
REQ-014 When en=1 and counter!=0, the counter SHALL decrement by 1 per cycle.
REQ-015 When en=1 and counter==0, the channel SHALL tick: the counter reloads div in the same edge.
REQ-016 Square-mode tick: phase SHALL toggle, giving out period 2*(div+1) cycles.
REQ-017 Noise-mode tick: LFSR SHALL shift as q <= {q[6:0], q[7]^q[5]^q[4]^q[3]}.
REQ-018 out[i] SHALL equal phase in square mode and q[0] in noise mode, registered one cycle after the state update.
REQ-019 div=0 SHALL tick every cycle, with no special-casing.
REQ-020 When en=0: counter SHALL be held at div, phase and LFSR held, out[i] forced to 0.
REQ-021 A write with cfg_we=1 and cfg_addr<CHANNELS SHALL update div, mode and en, and load the counter with cfg_div on the same edge.
REQ-022 A channel write SHALL NOT modify phase or LFSR.
REQ-023 A write with cfg_addr>=CHANNELS SHALL be ignored with no state change.
REQ-024 Simultaneous write and tick on the same channel: the write SHALL win; no toggle or shift occurs that cycle.
REQ-025 Channels SHALL be fully independent; a write to one channel SHALL NOT affect another.
REQ-026 active_count SHALL be the count of ones in out, registered one cycle after out.
REQ-027 The LFSR SHALL never reach all-zero; its period is 255 ticks.

Reset
REQ-028 While reset=1 at an edge, every channel SHALL set div=0, mode=0, en=0, counter=0, phase=0 and LFSR=8'h01.
REQ-029 While reset=1 at an edge, out=0 and active_count=0; reset SHALL override any concurrent cfg_we.
REQ-030 Reset mid-operation SHALL take effect on the next edge with no partial-state retention.
REQ-031 After reset, out SHALL stay 0 until a channel is enabled.

Verification
REQ-032 Square timing: reset, then write ch0 div=4, mode=0, en=1 at edge k -> phase toggles at k+5, k+10, ...; out[0] period 10 cycles, first rise at edge k+6.
REQ-033 Noise sequence: reset, then write ch1 div=0, mode=1, en=1 -> LFSR states 01, 02, 04, 08, 11 on successive cycles; out[1] shows 1, 0, 0, 0, 1 lagged one cycle; 255-tick period confirmed.
REQ-034 Disable and mix: all 4 channels in square mode with div=0 -> active_count toggles 0/4; disabling ch2 mid-run -> out[2]=0 next cycle and active_count alternates 0/3.
REQ-035 Collision: write ch0 div=9 on the exact cycle its counter hits 0 -> no toggle that cycle; next toggle 10 cycles later.
REQ-036 Illegal address and reset: write cfg_addr=CHANNELS -> no state change; assert reset for 1 cycle mid-run together with cfg_we -> all outputs 0 and LFSRs 8'h01 next cycle; write ignored.

Source files
------------

// File: rtl/tone_noise_bank.sv
`default_nettype none
// ============================================================================
// Module      : tone_noise_bank
// Description : Bank of independent square-wave / LFSR-noise tone generators.
//               Each channel owns a divisor, a down-counter that ticks every
//               div+1 cycles, a square-wave phase bit and an 8-bit noise LFSR.
//               Outputs are registered one cycle after the channel state, and
//               active_count is the registered popcount of the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_noise_bank #(
    parameter int CHANNELS   = 4,
    parameter int DIV_WIDTH  = 20,
    parameter int LFSR_WIDTH = 8,
    localparam int CNT_WIDTH = $clog2(CHANNELS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_addr,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic                 cfg_mode,
    input  logic                 cfg_en,
    output logic [CHANNELS-1:0]  out,
    output logic [CNT_WIDTH-1:0] active_count
);

    localparam logic [4:0]            c_NUM_CH    = 5'(CHANNELS);
    localparam logic [LFSR_WIDTH-1:0] c_LFSR_SEED = LFSR_WIDTH'(1);

    // Writes to addresses beyond the populated channels are dropped.
    logic                  w_addrOk;
    logic [CHANNELS-1:0]   w_outNext;
    logic [CNT_WIDTH-1:0]  w_popCount;

    assign w_addrOk = ({1'b0, cfg_addr} < c_NUM_CH);

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_chan
            logic [DIV_WIDTH-1:0]  r_div;
            logic                  r_mode;
            logic                  r_en;
            logic [DIV_WIDTH-1:0]  r_cnt;
            logic                  r_phase;
            logic [LFSR_WIDTH-1:0] r_lfsr;
            logic                  w_wrSel;
            logic                  w_fb;

            assign w_wrSel = cfg_we && w_addrOk && (cfg_addr == 4'(i));
            // Taps 8,6,5,4: maximal-length, so the all-zero state is unreachable
            assign w_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

            // Channel state: a config write beats a same-cycle tick, and a
            // write leaves phase and LFSR untouched.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_div   <= '0;
                    r_mode  <= 1'b0;
                    r_en    <= 1'b0;
                    r_cnt   <= '0;
                    r_phase <= 1'b0;
                    r_lfsr  <= c_LFSR_SEED;
                end else if (w_wrSel) begin
                    r_div  <= cfg_div;
                    r_mode <= cfg_mode;
                    r_en   <= cfg_en;
                    r_cnt  <= cfg_div;
                end else if (!r_en) begin
                    r_cnt <= r_div;
                end else if (r_cnt == '0) begin
                    r_cnt <= r_div;
                    if (r_mode) begin
                        r_lfsr <= {r_lfsr[LFSR_WIDTH-2:0], w_fb};
                    end else begin
                        r_phase <= ~r_phase;
                    end
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            assign w_outNext[i] = r_en && (r_mode ? r_lfsr[0] : r_phase);
        end
    endgenerate

    // Population count of the registered output vector
    always_comb begin
        w_popCount = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            w_popCount = w_popCount + CNT_WIDTH'(out[k]);
        end
    end

    // Output stage: out lags channel state by one cycle, active_count lags out
    always_ff @(posedge clk) begin
        if (reset) begin
            out          <= '0;
            active_count <= '0;
        end else begin
            out          <= w_outNext;
            active_count <= w_popCount;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tone_noise_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_noise_bank
// Description : Directed self-checking bench for tone_noise_bank (4 channels).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_noise_bank;

    localparam int CHANNELS  = 4;
    localparam int DIV_WIDTH = 20;
    localparam int CNT_WIDTH = 3;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 cfgWe = 1'b0;
    logic [3:0]           cfgAddr = '0;
    logic [DIV_WIDTH-1:0] cfgDiv = '0;
    logic                 cfgMode = 1'b0;
    logic                 cfgEn = 1'b0;
    logic [CHANNELS-1:0]  outBits;
    logic [CNT_WIDTH-1:0] activeCount;

    int vecCount  = 0;
    int missCount = 0;

    tone_noise_bank #(
        .CHANNELS  (CHANNELS),
        .DIV_WIDTH (DIV_WIDTH),
        .LFSR_WIDTH(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfgWe),
        .cfg_addr    (cfgAddr),
        .cfg_div     (cfgDiv),
        .cfg_mode    (cfgMode),
        .cfg_en      (cfgEn),
        .out         (outBits),
        .active_count(activeCount)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            missCount++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One configuration write, taking effect on the next rising edge
    task automatic cfgWrite(input logic [3:0] a, input logic [DIV_WIDTH-1:0] d,
                            input logic m, input logic e);
        cfgWe   = 1'b1;
        cfgAddr = a;
        cfgDiv  = d;
        cfgMode = m;
        cfgEn   = e;
        tick();
        cfgWe   = 1'b0;
    endtask

    function automatic logic [7:0] lfsrNext(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    initial begin : main
        logic [7:0] modelQ;
        logic       expBit;
        logic [4:0] noiseSeq;

        // ---------------- reset state ----------------
        applyReset();
        checkVal("rstOut", 32'(outBits), 32'h0);
        checkVal("rstCnt", 32'(activeCount), 32'h0);
        for (int j = 0; j < 3; j++) begin
            tick();
            checkVal("idleOut", 32'(outBits), 32'h0);
        end

        // ---------------- square timing + collision on ch0 ----------------
        applyReset();
        cfgWrite(4'd0, 20'd4, 1'b0, 1'b1);              // edge k
        for (int j = 1; j <= 19; j++) begin
            tick();
            expBit = 1'((((j - 1) / 5) % 2));
            checkVal("sqOut", 32'(outBits[0]), 32'(expBit));
            if (j >= 2) begin
                expBit = 1'((((j - 2) / 5) % 2));
                checkVal("sqCount", 32'(activeCount), 32'(expBit));
            end
        end
        checkVal("sqOthers", 32'(outBits[3:1]), 32'h0);
        // Edge k+20 is a tick edge for div=4: rewrite div=9 on it
        cfgWrite(4'd0, 20'd9, 1'b0, 1'b1);
        checkVal("colOut", 32'(outBits[0]), 32'h1);
        for (int j = 21; j <= 41; j++) begin
            tick();
            expBit = (j <= 30) ? 1'b1 : (j <= 40) ? 1'b0 : 1'b1;
            checkVal("colOut", 32'(outBits[0]), 32'(expBit));
        end

        // ---------------- noise sequence on ch1 ----------------
        applyReset();
        cfgWrite(4'd1, 20'd0, 1'b1, 1'b1);              // edge k, q=01
        noiseSeq = 5'b10001;                            // j=1..5 -> 1,0,0,0,1
        for (int j = 1; j <= 5; j++) begin
            tick();
            checkVal("noiseHead", 32'(outBits[1]), 32'(noiseSeq[5 - j]));
        end
        modelQ = 8'h11;                                 // state after edge k+4
        for (int j = 6; j <= 265; j++) begin
            modelQ = lfsrNext(modelQ);
            tick();
            checkVal("noiseSeq", 32'(outBits[1]), 32'(modelQ[0]));
        end

        // ---------------- mid-run reset with concurrent write ----------------
        reset   = 1'b1;
        cfgWe   = 1'b1;
        cfgAddr = 4'd1;
        cfgDiv  = 20'd0;
        cfgMode = 1'b1;
        cfgEn   = 1'b1;
        tick();
        reset = 1'b0;
        cfgWe = 1'b0;
        checkVal("midRstOut", 32'(outBits), 32'h0);
        checkVal("midRstCnt", 32'(activeCount), 32'h0);
        for (int j = 0; j < 3; j++) begin
            tick();
            checkVal("rstWrIgnored", 32'(outBits), 32'h0);
        end
        // LFSR must be back at 01: the noise head sequence repeats
        cfgWrite(4'd1, 20'd0, 1'b1, 1'b1);
        for (int j = 1; j <= 5; j++) begin
            tick();
            checkVal("reseedSeq", 32'(outBits[1]), 32'(noiseSeq[5 - j]));
        end

        // ---------------- four channels, div=0, then disable ch2 ----------------
        applyReset();
        cfgWrite(4'd0, 20'd0, 1'b0, 1'b1);              // m=0
        cfgWrite(4'd1, 20'd0, 1'b0, 1'b1);              // m=1
        cfgWrite(4'd2, 20'd0, 1'b0, 1'b1);              // m=2
        cfgWrite(4'd3, 20'd0, 1'b0, 1'b1);              // m=3
        cfgWrite(4'd1, 20'd0, 1'b0, 1'b1);              // m=4: skip one toggle
        cfgWrite(4'd3, 20'd0, 1'b0, 1'b1);              // m=5: skip one toggle
        for (int m = 6; m <= 11; m++) begin
            tick();
            if (m >= 8) begin
                checkVal("mixOut", 32'(outBits), (m % 2 == 0) ? 32'hF : 32'h0);
                checkVal("mixCount", 32'(activeCount), (m % 2 == 1) ? 32'd4 : 32'd0);
            end
        end
        cfgWrite(4'd2, 20'd0, 1'b0, 1'b0);              // m=12: disable ch2
        for (int m = 13; m <= 16; m++) begin
            tick();
            checkVal("disOut", 32'(outBits), (m % 2 == 0) ? 32'hB : 32'h0);
            if (m >= 14) begin
                checkVal("disCount", 32'(activeCount), (m % 2 == 1) ? 32'd3 : 32'd0);
            end
        end
        cfgWrite(4'd4, 20'd5, 1'b1, 1'b0);              // m=17: illegal address
        checkVal("illOut17", 32'(outBits), 32'h0);
        cfgWrite(4'd15, 20'd7, 1'b1, 1'b0);             // m=18: illegal address
        checkVal("illOut18", 32'(outBits), 32'hB);
        checkVal("illCount18", 32'(activeCount), 32'd0);
        tick();                                         // m=19
        checkVal("illOut19", 32'(outBits), 32'h0);
        checkVal("illCount19", 32'(activeCount), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin : watchdog
        #200000;
        missCount++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
`default_nettype wire
